pwm_ramp_ctrl: RTL and testbench

Sequencer that drives the duty_cycle and period inputs of the PWM block to produce repeated fade (breathing) profiles. It ramps duty up from a minimum to a maximum, holds, ramps back down, holds again, and repeats a programmable number of loops. It keeps its own period counter, which mirrors the PWM counter, so duty changes land only on PWM period boundaries and no partial period is ever produced.

---
 rtl/pwm_ctrl_pkg.sv | 42 ++++
 rtl/pwm_period_timer.sv | 32 +++
 rtl/pwm_ramp_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM fade (breathing) sequencer.
package pwm_ctrl_pkg;

  localparam int W_DEF      = 16;
  localparam int LOOP_W_DEF = 8;
  localparam int ARITH_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HIGH = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LOW  = 3'd4
  } state_e;

  // a + b clamped to lim; the extra carry bit keeps the compare exact on overflow.
  function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b,
                                                 input logic [ARITH_W-1:0] lim);
    logic [ARITH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return lim;
    end else begin
      return sum[ARITH_W-1:0];
    end
  endfunction

  // a - b clamped to lo; compares against lo + b so nothing underflows.
  function automatic logic [ARITH_W-1:0] sat_sub(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b,
                                                 input logic [ARITH_W-1:0] lo);
    logic [ARITH_W:0] thr;
    thr = {1'b0, lo} + {1'b0, b};
    if ({1'b0, a} < thr) begin
      return lo;
    end else begin
      return a - b;
    end
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Period counter mirroring the PWM counter; flags the last clock of each period.
module pwm_period_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);

  logic [W-1:0] r_pcnt;
  logic         w_last;

  assign w_last = (r_pcnt == (i_period - W'(1)));
  assign o_tick = i_en & w_last;

  // Count 0..period-1 while enabled, wrap on the last clock, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= W'(0);
    end else if (i_clr) begin
      r_pcnt <= W'(0);
    end else if (i_en) begin
      r_pcnt <= w_last ? W'(0) : (r_pcnt + W'(1));
    end else begin
      r_pcnt <= r_pcnt;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Fade sequencer: ramps PWM duty min->max, holds, ramps down, holds, loops.
// Every duty/state change is gated by the period tick so the PWM never sees
// a partial period.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [W-1:0]      i_period_cfg,
  input  logic [W-1:0]      i_duty_min,
  input  logic [W-1:0]      i_duty_max,
  input  logic [W-1:0]      i_step,
  input  logic [W-1:0]      i_rate_div,
  input  logic [W-1:0]      i_hold_periods,
  input  logic [LOOP_W-1:0] i_loops,
  output logic [W-1:0]      o_period_out,
  output logic [W-1:0]      o_duty_out,
  output logic              o_period_tick,
  output logic              o_busy,
  output logic              o_done
);

  state_e r_state, w_state_nx;

  logic [W-1:0]      r_period_l, r_min_l, r_max_l, r_step_l, r_rate_l, r_hold_l;
  logic [LOOP_W-1:0] r_loops_l;
  logic [W-1:0]      r_duty, r_divcnt, r_holdcnt;
  logic [LOOP_W-1:0] r_loopcnt;
  logic              r_busy, r_done, r_stop_pend;

  logic [W-1:0]      w_period_l_nx, w_min_l_nx, w_max_l_nx, w_step_l_nx, w_rate_l_nx, w_hold_l_nx;
  logic [LOOP_W-1:0] w_loops_l_nx;
  logic [W-1:0]      w_duty_nx, w_divcnt_nx, w_holdcnt_nx;
  logic [LOOP_W-1:0] w_loopcnt_nx, w_loop_inc;
  logic              w_busy_nx, w_done_nx, w_stop_pend_nx;
  logic              w_start_acc, w_go_idle, w_tick;
  logic [W-1:0]      w_up, w_dn;

  pwm_period_timer #(.W(W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_busy),
    .i_clr    (w_start_acc | w_go_idle),
    .i_period (r_period_l),
    .o_tick   (w_tick)
  );

  assign w_up = W'(sat_add(ARITH_W'(r_duty), ARITH_W'(r_step_l), ARITH_W'(r_max_l)));
  assign w_dn = W'(sat_sub(ARITH_W'(r_duty), ARITH_W'(r_step_l), ARITH_W'(r_min_l)));

  assign o_period_out  = r_period_l;
  assign o_duty_out    = r_duty;
  assign o_period_tick = w_tick;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

  // Next-state and datapath decisions; only the tick lets anything advance.
  always_comb begin
    w_state_nx     = r_state;
    w_period_l_nx  = r_period_l;
    w_min_l_nx     = r_min_l;
    w_max_l_nx     = r_max_l;
    w_step_l_nx    = r_step_l;
    w_rate_l_nx    = r_rate_l;
    w_hold_l_nx    = r_hold_l;
    w_loops_l_nx   = r_loops_l;
    w_duty_nx      = r_duty;
    w_divcnt_nx    = r_divcnt;
    w_holdcnt_nx   = r_holdcnt;
    w_loopcnt_nx   = r_loopcnt;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_stop_pend_nx = r_stop_pend;
    w_start_acc    = 1'b0;
    w_go_idle      = 1'b0;
    w_loop_inc     = r_loopcnt + LOOP_W'(1);

    if (r_state == ST_IDLE) begin
      if (i_start) begin
        // Zero fields are treated as 1; an inverted range collapses to flat.
        w_start_acc    = 1'b1;
        w_period_l_nx  = (i_period_cfg   == W'(0)) ? W'(1) : i_period_cfg;
        w_step_l_nx    = (i_step         == W'(0)) ? W'(1) : i_step;
        w_rate_l_nx    = (i_rate_div     == W'(0)) ? W'(1) : i_rate_div;
        w_hold_l_nx    = (i_hold_periods == W'(0)) ? W'(1) : i_hold_periods;
        w_min_l_nx     = i_duty_min;
        w_max_l_nx     = (i_duty_min > i_duty_max) ? i_duty_min : i_duty_max;
        w_loops_l_nx   = i_loops;
        w_duty_nx      = i_duty_min;
        w_divcnt_nx    = W'(0);
        w_holdcnt_nx   = W'(0);
        w_loopcnt_nx   = LOOP_W'(0);
        w_busy_nx      = 1'b1;
        w_stop_pend_nx = 1'b0;
        w_state_nx     = ST_RAMP_UP;
      end else begin
        w_stop_pend_nx = 1'b0;
      end
    end else begin
      w_stop_pend_nx = r_stop_pend | i_stop;
      if (w_tick) begin
        if (r_stop_pend | i_stop) begin
          w_go_idle = 1'b1;
        end else begin
          case (r_state)
            ST_RAMP_UP: begin
              if (r_divcnt == (r_rate_l - W'(1))) begin
                w_divcnt_nx = W'(0);
                w_duty_nx   = w_up;
                if (w_up == r_max_l) begin
                  w_state_nx   = ST_HOLD_HIGH;
                  w_holdcnt_nx = W'(0);
                end else begin
                  w_state_nx = ST_RAMP_UP;
                end
              end else begin
                w_divcnt_nx = r_divcnt + W'(1);
              end
            end
            ST_HOLD_HIGH: begin
              if (r_holdcnt == (r_hold_l - W'(1))) begin
                w_state_nx   = ST_RAMP_DOWN;
                w_divcnt_nx  = W'(0);
                w_holdcnt_nx = W'(0);
              end else begin
                w_holdcnt_nx = r_holdcnt + W'(1);
              end
            end
            ST_RAMP_DOWN: begin
              if (r_divcnt == (r_rate_l - W'(1))) begin
                w_divcnt_nx = W'(0);
                w_duty_nx   = w_dn;
                if (w_dn == r_min_l) begin
                  w_state_nx   = ST_HOLD_LOW;
                  w_holdcnt_nx = W'(0);
                end else begin
                  w_state_nx = ST_RAMP_DOWN;
                end
              end else begin
                w_divcnt_nx = r_divcnt + W'(1);
              end
            end
            ST_HOLD_LOW: begin
              if (r_holdcnt == (r_hold_l - W'(1))) begin
                w_loopcnt_nx = w_loop_inc;
                if ((r_loops_l != LOOP_W'(0)) && (w_loop_inc == r_loops_l)) begin
                  w_go_idle = 1'b1;
                end else begin
                  w_state_nx   = ST_RAMP_UP;
                  w_divcnt_nx  = W'(0);
                  w_holdcnt_nx = W'(0);
                end
              end else begin
                w_holdcnt_nx = r_holdcnt + W'(1);
              end
            end
            default: begin
              w_go_idle = 1'b1;
            end
          endcase
        end
      end else begin
        w_go_idle = 1'b0;
      end
    end

    if (w_go_idle) begin
      // Return to idle: duty parked at 0, period_out left at its last value.
      w_state_nx     = ST_IDLE;
      w_duty_nx      = W'(0);
      w_busy_nx      = 1'b0;
      w_done_nx      = 1'b1;
      w_stop_pend_nx = 1'b0;
      w_divcnt_nx    = W'(0);
      w_holdcnt_nx   = W'(0);
      w_loopcnt_nx   = LOOP_W'(0);
    end else begin
      w_done_nx = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Latched configuration, duty, counters and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_l  <= W'(0);
      r_min_l     <= W'(0);
      r_max_l     <= W'(0);
      r_step_l    <= W'(0);
      r_rate_l    <= W'(0);
      r_hold_l    <= W'(0);
      r_loops_l   <= LOOP_W'(0);
      r_duty      <= W'(0);
      r_divcnt    <= W'(0);
      r_holdcnt   <= W'(0);
      r_loopcnt   <= LOOP_W'(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_period_l  <= w_period_l_nx;
      r_min_l     <= w_min_l_nx;
      r_max_l     <= w_max_l_nx;
      r_step_l    <= w_step_l_nx;
      r_rate_l    <= w_rate_l_nx;
      r_hold_l    <= w_hold_l_nx;
      r_loops_l   <= w_loops_l_nx;
      r_duty      <= w_duty_nx;
      r_divcnt    <= w_divcnt_nx;
      r_holdcnt   <= w_holdcnt_nx;
      r_loopcnt   <= w_loopcnt_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_stop_pend <= w_stop_pend_nx;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: a per-period duty profile model
// expanded to per-clock expectations of {busy, done, tick, duty, period}.
module tb_pwm_ramp_ctrl;

  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk, rst_n, i_start, i_stop;
  logic [W-1:0]  i_period_cfg, i_duty_min, i_duty_max, i_step, i_rate_div, i_hold_periods;
  logic [LW-1:0] i_loops;
  logic [W-1:0]  o_period_out, o_duty_out;
  logic          o_period_tick, o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;
  int pd[$];
  logic [34:0] exp_q[$];
  logic [34:0] obs;
  int basic_duty[6] = '{0, 2, 4, 4, 2, 0};
  int sat_duty[8]   = '{1, 5, 9, 10, 10, 6, 2, 1};

  pwm_ramp_ctrl #(.W(W), .LOOP_W(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_period_cfg   (i_period_cfg),
    .i_duty_min     (i_duty_min),
    .i_duty_max     (i_duty_max),
    .i_step         (i_step),
    .i_rate_div     (i_rate_div),
    .i_hold_periods (i_hold_periods),
    .i_loops        (i_loops),
    .o_period_out   (o_period_out),
    .o_duty_out     (o_duty_out),
    .o_period_tick  (o_period_tick),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input int per, input int mn, input int mx, input int st,
                         input int rt, input int hd, input int lp);
    i_period_cfg   = W'(per);
    i_duty_min     = W'(mn);
    i_duty_max     = W'(mx);
    i_step         = W'(st);
    i_rate_div     = W'(rt);
    i_hold_periods = W'(hd);
    i_loops        = LW'(lp);
  endtask

  task automatic pulse_start;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Profile model: list duty per PWM period, then expand to clocks.
  // stop_p >= 0 truncates the run after that period index.
  task automatic build_exp(input int per, input int mn, input int mx, input int st,
                           input int rt, input int hd, input int lp, input int stop_p);
    int p, r, h, s, hi, d, nl;
    p  = (per == 0) ? 1 : per;
    r  = (rt == 0) ? 1 : rt;
    h  = (hd == 0) ? 1 : hd;
    s  = (st == 0) ? 1 : st;
    hi = (mn > mx) ? mn : mx;
    d  = mn;
    nl = 0;
    pd.delete();
    exp_q.delete();
    while ((lp != 0 && nl < lp) || (lp == 0 && pd.size() <= stop_p)) begin
      do begin
        repeat (r) pd.push_back(d);
        d = (d + s > hi) ? hi : d + s;
      end while (d != hi);
      repeat (h) pd.push_back(d);
      do begin
        repeat (r) pd.push_back(d);
        d = (d < mn + s) ? mn : d - s;
      end while (d != mn);
      repeat (h) pd.push_back(d);
      nl++;
    end
    if (stop_p >= 0) begin
      while (pd.size() > stop_p + 1) void'(pd.pop_back());
    end
    for (int i = 0; i < pd.size(); i++) begin
      for (int c = 0; c < p; c++) begin
        exp_q.push_back({1'b1, 1'b0, (c == p - 1), W'(pd[i]), W'(p)});
      end
    end
    exp_q.push_back({1'b0, 1'b1, 1'b0, W'(0), W'(p)});
    exp_q.push_back({1'b0, 1'b0, 1'b0, W'(0), W'(p)});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
    n_checks++;
    if (obs !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=0", obs);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== 35'h0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", k, obs);
      end
    end
  endtask

  task automatic test_basic;
    int done_at;
    done_at = -1;
    set_cfg(4, 0, 4, 2, 1, 1, 1);
    build_exp(4, 0, 4, 2, 1, 1, 1, -1);
    pulse_start();
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      if (k < 24 && (k % 4) == 0) begin
        n_checks++;
        if (o_duty_out !== W'(basic_duty[k / 4])) begin
          n_fail++;
          $display("FAIL basic_duty period=%0d got=%0d exp=%0d", k / 4, o_duty_out, basic_duty[k / 4]);
        end
      end
      if (o_done === 1'b1 && done_at < 0) done_at = k;
      @(negedge clk);
    end
    n_checks++;
    if (done_at != 24) begin
      n_fail++;
      $display("FAIL basic_done_time got=%0d exp=24", done_at);
    end
  endtask

  task automatic test_saturation;
    set_cfg(2, 1, 10, 4, 1, 1, 1);
    build_exp(2, 1, 10, 4, 1, 1, 1, -1);
    pulse_start();
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL saturation cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      if (k < 16 && (k % 2) == 0) begin
        n_checks++;
        if (o_duty_out !== W'(sat_duty[k / 2])) begin
          n_fail++;
          $display("FAIL sat_duty period=%0d got=%0d exp=%0d", k / 2, o_duty_out, sat_duty[k / 2]);
        end
      end
      if (o_busy === 1'b1) begin
        n_checks++;
        if (o_duty_out > W'(10) || o_duty_out < W'(1)) begin
          n_fail++;
          $display("FAIL sat_bounds cyc=%0d got=%0d exp=1..10", k, o_duty_out);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rate_hold;
    set_cfg(3, 0, 2, 1, 2, 3, 1);
    build_exp(3, 0, 2, 1, 2, 3, 1, -1);
    pulse_start();
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL rate_hold cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop;
    set_cfg(5, 0, 8, 1, 1, 2, 0);
    build_exp(5, 0, 8, 1, 1, 2, 0, 3);
    pulse_start();
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      i_stop = (k == 3 * 5 + 1);
      @(negedge clk);
    end
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== {3'b000, W'(0), W'(5)}) begin
        n_fail++;
        $display("FAIL stop_idle cyc=%0d got=%h exp=%h", k, obs, {3'b000, W'(0), W'(5)});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_edge;
    set_cfg(0, 0, 3, 0, 0, 0, 1);
    build_exp(0, 0, 3, 0, 0, 0, 1, -1);
    pulse_start();
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL zero_cfg cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      @(negedge clk);
    end
    set_cfg(3, 7, 3, 2, 1, 2, 2);
    build_exp(3, 7, 3, 2, 1, 2, 2, -1);
    pulse_start();
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL flat_busy_start cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      if (o_busy === 1'b1) begin
        n_checks++;
        if (o_duty_out !== W'(7)) begin
          n_fail++;
          $display("FAIL flat_duty cyc=%0d got=%0d exp=7", k, o_duty_out);
        end
      end
      i_start = (k == 5);
      if (k == 5) set_cfg(6, 0, 50, 5, 3, 1, 0);
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic test_async_reset;
    set_cfg(4, 0, 4, 2, 1, 3, 1);
    build_exp(4, 0, 4, 2, 1, 3, 1, -1);
    pulse_start();
    for (int k = 0; k <= 10; k++) begin
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
      if (k < 10) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
    n_checks++;
    if (obs !== 35'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", obs);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
      n_checks++;
      if (obs !== 35'h0) begin
        n_fail++;
        $display("FAIL reset_no_done cyc=%0d got=%h exp=0", k, obs);
      end
    end
  endtask

  task automatic test_random;
    int per, mn, mx, st, rt, hd, lp;
    for (int it = 0; it < 6; it++) begin
      per = $urandom_range(0, 4);
      mn  = $urandom_range(0, 12);
      mx  = $urandom_range(0, 12);
      st  = $urandom_range(0, 5);
      rt  = $urandom_range(0, 2);
      hd  = $urandom_range(0, 2);
      lp  = $urandom_range(1, 2);
      set_cfg(per, mn, mx, st, rt, hd, lp);
      build_exp(per, mn, mx, st, rt, hd, lp, -1);
      pulse_start();
      for (int k = 0; k < exp_q.size(); k++) begin
        obs = {o_busy, o_done, o_period_tick, o_duty_out, o_period_out};
        n_checks++;
        if (obs !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random it=%0d cfg=%0d/%0d/%0d/%0d/%0d/%0d/%0d cyc=%0d got=%h exp=%h",
                   it, per, mn, mx, st, rt, hd, lp, k, obs, exp_q[k]);
        end
        if (k == 3) set_cfg($urandom_range(0, 9), $urandom_range(0, 30), $urandom_range(0, 30),
                            $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rate_hold();
    test_stop();
    test_edge();
    test_async_reset();
    test_basic();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
